// File: rtl/alexnet_pkg.sv
// Shared types and helpers for the convolution front-end controllers.
// Holds the scheduler state encoding and output-map dimension arithmetic.
package alexnet_pkg;

    localparam int CNT_W_DEF = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } sched_state_e;

    // Number of window positions along one dimension (trailing remainder dropped).
    function automatic int out_dim(input int size, input int kernel, input int stride);
        return (size - kernel) / stride + 1;
    endfunction

endpackage

// File: rtl/conv_window_sched_stride_counter.sv
// Position counter with a stride-phase counter; flags positions that close a window.
// Phase stays 0 until the first full kernel span, then cycles modulo STRIDE.
module stride_counter
    import alexnet_pkg::*;
#(
    parameter int LIMIT  = 227,
    parameter int KERNEL = 11,
    parameter int STRIDE = 4,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic en,
    output logic hit,
    output logic wrap
);

    localparam logic [CNT_W-1:0] LIMIT_M1  = CNT_W'(LIMIT - 1);
    localparam logic [CNT_W-1:0] KERNEL_M1 = CNT_W'(KERNEL - 1);
    localparam logic [CNT_W-1:0] STRIDE_M1 = CNT_W'(STRIDE - 1);

    logic [CNT_W-1:0] pos;
    logic [CNT_W-1:0] phase;

    assign wrap = (pos == LIMIT_M1);
    assign hit  = (pos >= KERNEL_M1) && (phase == '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pos   <= '0;
            phase <= '0;
        end else if (clear) begin
            pos   <= '0;
            phase <= '0;
        end else if (en) begin
            if (wrap) begin
                pos   <= '0;
                phase <= '0;
            end else begin
                pos <= pos + 1'b1;
                // Phase only starts advancing once the first window has closed.
                if (pos < KERNEL_M1 || phase == STRIDE_M1)
                    phase <= '0;
                else
                    phase <= phase + 1'b1;
            end
        end
    end

endmodule

// File: rtl/conv_window_sched.sv
// Frame sequencer between the line buffer and the MAC array: walks one raster frame,
// emits output-map coordinates for every completed window and throttles on MAC stalls.
module conv_window_sched
    import alexnet_pkg::*;
#(
    parameter int WIDTH  = 227,
    parameter int HEIGHT = 227,
    parameter int KERNEL = 11,
    parameter int STRIDE = 4,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             win_valid,
    input  logic             win_ready,
    output logic [CNT_W-1:0] win_row,
    output logic [CNT_W-1:0] win_col,
    output logic             busy,
    output logic             done,
    output logic [1:0]       dbg_state
);

    // Handshake: a pixel moves when in_valid & in_ready, a window moves when
    // win_valid & win_ready; both may happen in the same cycle.
    localparam logic [1:0] S_IDLE  = ST_IDLE;
    localparam logic [1:0] S_RUN   = ST_RUN;
    localparam logic [1:0] S_DRAIN = ST_DRAIN;
    localparam logic [1:0] S_DONE  = ST_DONE;

    localparam logic [CNT_W-1:0] OUT_W_M1 = CNT_W'(out_dim(WIDTH, KERNEL, STRIDE) - 1);

    logic [1:0]       state;
    logic [CNT_W-1:0] out_row;
    logic [CNT_W-1:0] out_col;
    logic             accept;
    logic             col_hit;
    logic             col_wrap;
    logic             row_hit;
    logic             row_wrap;
    logic             win_hit;
    logic             frame_end;
    logic             clear;

    assign in_ready  = (state == S_RUN) & ~(win_valid & ~win_ready);
    assign accept    = in_valid & in_ready;
    assign win_hit   = accept & col_hit & row_hit;
    assign frame_end = accept & col_wrap & row_wrap;
    assign clear     = (state == S_IDLE) & start;

    assign busy      = (state == S_RUN) | (state == S_DRAIN);
    assign done      = (state == S_DONE);
    assign dbg_state = state;

    stride_counter #(
        .LIMIT (WIDTH),
        .KERNEL(KERNEL),
        .STRIDE(STRIDE),
        .CNT_W (CNT_W)
    ) u_col (
        .clk  (clk),
        .reset(reset),
        .clear(clear),
        .en   (accept),
        .hit  (col_hit),
        .wrap (col_wrap)
    );

    stride_counter #(
        .LIMIT (HEIGHT),
        .KERNEL(KERNEL),
        .STRIDE(STRIDE),
        .CNT_W (CNT_W)
    ) u_row (
        .clk  (clk),
        .reset(reset),
        .clear(clear),
        .en   (accept & col_wrap),
        .hit  (row_hit),
        .wrap (row_wrap)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            case (state)
                S_IDLE:  if (start) state <= S_RUN;
                S_RUN:   if (frame_end) state <= S_DRAIN;
                S_DRAIN: if (!win_valid || win_ready) state <= S_DONE;
                default: state <= S_IDLE;
            endcase
        end
    end

    // A row of hits always holds exactly OUT_W windows, so the last one advances the row.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            win_valid <= 1'b0;
            win_row   <= '0;
            win_col   <= '0;
            out_row   <= '0;
            out_col   <= '0;
        end else if (clear) begin
            win_valid <= 1'b0;
            out_row   <= '0;
            out_col   <= '0;
        end else if (win_hit) begin
            win_valid <= 1'b1;
            win_row   <= out_row;
            win_col   <= out_col;
            if (out_col == OUT_W_M1) begin
                out_col <= '0;
                out_row <= out_row + 1'b1;
            end else begin
                out_col <= out_col + 1'b1;
            end
        end else if (win_ready) begin
            win_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_conv_window_sched.sv
// Randomized frame-level bench for conv_window_sched over several frame geometries,
// checked against a pixel-arithmetic reference model and an expected-window queue.
module tb_conv_window_sched;
  import alexnet_pkg::*;

  localparam int NCFG = 4;
  localparam int KK = 3;

  function automatic int cfg_w(input int g);
    return (g == 2) ? 6 : (g == 3) ? 7 : 5;
  endfunction
  function automatic int cfg_h(input int g);
    return (g == 3) ? 6 : 5;
  endfunction
  function automatic int cfg_s(input int g);
    return (g == 0) ? 1 : 2;
  endfunction

  logic clk;
  logic reset;
  logic start_a     [NCFG];
  logic in_valid_a  [NCFG];
  logic win_ready_a [NCFG];
  logic in_ready_a  [NCFG];
  logic win_valid_a [NCFG];
  logic busy_a      [NCFG];
  logic done_a      [NCFG];
  logic [7:0] win_row_a [NCFG];
  logic [7:0] win_col_a [NCFG];
  logic [1:0] dbg_a     [NCFG];

  int total = 0;
  int bad = 0;
  logic [15:0] exp_q[$];

  for (genvar g = 0; g < NCFG; g++) begin : g_dut
    conv_window_sched #(
      .WIDTH (cfg_w(g)),
      .HEIGHT(cfg_h(g)),
      .KERNEL(KK),
      .STRIDE(cfg_s(g)),
      .CNT_W (8)
    ) dut (
      .clk      (clk),
      .reset    (reset),
      .start    (start_a[g]),
      .in_valid (in_valid_a[g]),
      .in_ready (in_ready_a[g]),
      .win_valid(win_valid_a[g]),
      .win_ready(win_ready_a[g]),
      .win_row  (win_row_a[g]),
      .win_col  (win_col_a[g]),
      .busy     (busy_a[g]),
      .done     (done_a[g]),
      .dbg_state(dbg_a[g])
    );
  end

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d exp=%0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic bit is_hit(input int v, input int k, input int s);
    return (v >= k - 1) && (((v - (k - 1)) % s) == 0);
  endfunction

  task automatic check_idle_outputs(input int k, input string tag);
    check({tag, "_in_ready"}, in_ready_a[k], 0);
    check({tag, "_win_valid"}, win_valid_a[k], 0);
    check({tag, "_win_row"}, win_row_a[k], 0);
    check({tag, "_win_col"}, win_col_a[k], 0);
    check({tag, "_busy"}, busy_a[k], 0);
    check({tag, "_done"}, done_a[k], 0);
  endtask

  // phase: 0 idle, 1 run, 2 drain, 3 done
  task automatic run_frame(input int k, input int rdy_pct, input int vld_pct,
                           input bit hold, input bit extra_start, input int abort_at);
    int w, h, s, npix, pix, phase, wins, cycles, hf, hd, r, c, exp_n;
    bit pend, acc, hs, exp_rdy;
    w = cfg_w(k); h = cfg_h(k); s = cfg_s(k);
    npix = w * h;
    exp_n = ((w - KK) / s + 1) * ((h - KK) / s + 1);
    exp_q.delete();
    for (int rr = 0; rr < h; rr++)
      for (int cc = 0; cc < w; cc++)
        if (is_hit(rr, KK, s) && is_hit(cc, KK, s))
          exp_q.push_back({8'((rr - KK + 1) / s), 8'((cc - KK + 1) / s)});

    start_a[k] = 1'b1; in_valid_a[k] = 1'b0; win_ready_a[k] = 1'b0;
    #1;
    check("pre_start_busy", busy_a[k], 0);
    @(negedge clk);
    start_a[k] = 1'b0;
    pix = 0; phase = 1; wins = 0; cycles = 0; hf = 0; hd = 0; pend = 0;

    while (phase != 0) begin
      if (abort_at > 0 && pix == abort_at && phase == 1) begin
        reset = 1'b1; in_valid_a[k] = 1'b0;
        @(negedge clk);
        #1;
        check_idle_outputs(k, "abort");
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
          @(negedge clk);
          check("abort_no_done", done_a[k], 0);
        end
        exp_q.delete();
        return;
      end

      in_valid_a[k]  = ($urandom_range(99) < vld_pct);
      win_ready_a[k] = ($urandom_range(99) < rdy_pct);
      if (hold && pend && wins == 0 && hf < 3) begin win_ready_a[k] = 1'b0; hf++; end
      if (hold && phase == 2 && hd < 2) begin win_ready_a[k] = 1'b0; hd++; end
      start_a[k] = extra_start && (cycles == 5);
      #1;

      exp_rdy = (phase == 1) && !(pend && !win_ready_a[k]);
      check("win_valid", win_valid_a[k], pend);
      if (pend && exp_q.size() > 0)
        check("win_coord", {win_row_a[k], win_col_a[k]}, exp_q[0]);
      check("in_ready", in_ready_a[k], exp_rdy);
      check("busy", busy_a[k], (phase == 1 || phase == 2));
      check("done", done_a[k], (phase == 3));

      acc = in_valid_a[k] && exp_rdy;
      hs = pend && win_ready_a[k];
      if (hs) begin
        wins++;
        if (exp_q.size() > 0) void'(exp_q.pop_front());
      end
      case (phase)
        1: begin
          if (hs) pend = 0;
          if (acc) begin
            r = pix / w; c = pix % w;
            if (is_hit(r, KK, s) && is_hit(c, KK, s)) pend = 1;
            pix++;
            if (pix == npix) phase = 2;
          end
        end
        2: begin
          if (!pend || win_ready_a[k]) phase = 3;
          if (hs) pend = 0;
        end
        default: phase = 0;
      endcase

      @(negedge clk);
      cycles++;
      if (cycles > 4000) begin
        check("timeout", 1, 0);
        phase = 0;
      end
    end
    start_a[k] = 1'b0; in_valid_a[k] = 1'b0; win_ready_a[k] = 1'b0;
    #1;
    check("end_done_low", done_a[k], 0);
    check("end_busy_low", busy_a[k], 0);
    check("end_state_idle", dbg_a[k], ST_IDLE);
    check("win_count", wins, exp_n);
    check("exp_q_empty", exp_q.size(), 0);
  endtask

  initial begin
    reset = 1'b1;
    for (int k = 0; k < NCFG; k++) begin
      start_a[k] = 1'b0; in_valid_a[k] = 1'b0; win_ready_a[k] = 1'b0;
    end
    repeat (2) @(negedge clk);
    #1;
    for (int k = 0; k < NCFG; k++) begin
      check_idle_outputs(k, "reset");
      check("reset_state", dbg_a[k], ST_IDLE);
    end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    run_frame(0, 100, 100, 0, 0, 0);
    run_frame(1, 100, 100, 0, 0, 0);
    run_frame(2, 100, 100, 0, 0, 0);
    run_frame(0, 100, 100, 1, 0, 0);
    run_frame(1, 60, 70, 1, 0, 0);
    run_frame(3, 50, 60, 0, 1, 0);
    run_frame(0, 100, 100, 0, 0, 10);
    run_frame(0, 70, 80, 0, 0, 0);
    for (int i = 0; i < 8; i++)
      run_frame(i % NCFG, $urandom_range(100, 20), $urandom_range(100, 30), i[0], i[1], 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
